bcd_cook_timer: RTL and testbench
=================================

# bcd_cook_timer

Parametrised MM:SS cook-timer core: debounces the user buttons, lets the user set minutes/seconds in BCD, then counts down at a configurable tick rate with pause/resume and a timed alarm. Adds auto-repeat on held set buttons, pause, a clear input and an alarm phase, and drives the four BCD digits to the display mux in `top`. A single `clk`-domain block; all outputs registered.

## Interface
- `TICK_DIV`, 100_000_000: `clk` cycles per one-second tick; must be ≥2.
- `DB_CYCLES`, 1_000_000: consecutive stable cycles needed before a debounced level changes; must be ≥1.
- `REPEAT_CYCLES`, 25_000_000: auto-repeat interval for a held set button; 0 disables auto-repeat.
- `ALARM_SECS`, 5: alarm duration in ticks; must be ≥1.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cook_time` in 1: level; high requests SET mode. Synchronised (2 flops) but not debounced.
- `minutes_up` in 1: raw button, increments minutes.
- `seconds_up` in 1: raw button, increments seconds.
- `start` in 1: raw button; acts as start/pause toggle and alarm acknowledge.
- `clear` in 1: synchronous level; zeroes the time and returns to IDLE.
- `second_ones`, `second_tens`, `minute_ones`, `minute_tens` out 4 each: BCD time digits.
- `debounce_min`, `debounce_sec` out 1: debounced levels of `minutes_up` and `seconds_up`.
- `enable_timer_cooktime` out 1: high while in SET.
- `running` out 1: high while in RUN.
- `alarm` out 1: high while in DONE.

## Operation
- Each raw button passes through a 2-flop synchroniser, then a stability counter. The debounced level takes the new value after the synchronised input has held it for `DB_CYCLES` consecutive cycles. Any bounce restarts the count.
- A one-cycle pulse is generated on each rising edge of a debounced level.
- Auto-repeat applies in SET only, when `REPEAT_CYCLES` > 0. While a debounced set button stays high, an extra pulse fires every `REPEAT_CYCLES` cycles after the previous pulse.
- Time range: minutes 00–99, seconds 00–59.
  - `minutes_up` pulse: 99→00 wrap.
  - `seconds_up` pulse: 59→00 wrap, with no carry into minutes.
  - Simultaneous minute and second pulses both apply in the same cycle.
- Decrement on each tick: if SS>0, SS-1; else if MM>0, MM-1 and SS=59.
- FSM states and transitions:
  - IDLE: `cook_time`=1 → SET. Start pulse with time ≠ 00:00 → RUN. Start pulse at 00:00 is ignored.
  - SET: increments are applied here and in no other state. `cook_time`=0 → IDLE. Start is ignored.
  - RUN: decrement on each tick. The tick that produces 00:00 moves the FSM to DONE in the same cycle. Start pulse → PAUSE. `cook_time` is ignored.
  - PAUSE: digits held. Start pulse → RUN. `cook_time`=1 → SET.
  - DONE: digits stay 00:00. After `ALARM_SECS` ticks → IDLE. Start pulse → IDLE. `cook_time`=1 → SET.
- `clear`=1 in any state → IDLE with all digits 0 on the next edge. `clear` has priority over every event except reset.
- A start pulse and a tick in the same RUN cycle: apply the decrement, then go to PAUSE (or DONE if the result is 00:00; DONE wins).

## Timing
- Reset (async, `reset`=0): state IDLE, all digits 0, all outputs 0, all counters and synchronisers 0.
- Debounce latency: `debounce_*` rises `DB_CYCLES`+2 cycles after a clean raw rising edge. The digit change is visible one cycle later.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 in RUN and DONE only.
  - Cleared on every entry to RUN or DONE.
  - A tick fires when the count equals `TICK_DIV`-1.
  - The first decrement lands `TICK_DIV` cycles after entering RUN. Resume from PAUSE always waits a full `TICK_DIV`.
- `running`, `alarm` and `enable_timer_cooktime` are decoded from the registered state and change in the same cycle as the state.
- Deasserting reset mid-run restarts cleanly in IDLE at 00:00.

## Test plan
All scenarios use `TICK_DIV`=4, `DB_CYCLES`=3, `REPEAT_CYCLES`=0 unless stated, `ALARM_SECS`=2.
- Set and count: `cook_time`=1; two clean `minutes_up` presses and three `seconds_up` presses; `cook_time`=0; press `start`. Required: display shows 02:03; `running`=1; display reads 02:02 exactly 4 cycles after RUN entry, then 02:01 after 4 more.
- Borrow and done: load 01:00 and run. Required: 00:59 after one tick; at 00:00, `alarm`=1 for 8 cycles, then IDLE with `alarm`=0.
- Debounce: toggle `seconds_up` every 2 cycles for 20 cycles, then hold high. Required: no increment during bouncing; exactly one increment, with `debounce_sec` rising 5 cycles after the hold begins.
- Wrap and auto-repeat (`REPEAT_CYCLES`=8): seconds at 58, hold `seconds_up` for 30 cycles. Required: 59, 00, 01, 02 at 8-cycle spacing; minutes unchanged.
- Pause and clear: in RUN at 00:10, press `start`. Required: PAUSE, digits frozen. Press `start` again: next decrement a full 4 cycles later. Assert `clear`: 00:00 and IDLE next cycle.
- Async reset mid-RUN: drive `reset`=0 between clock edges. Required: all outputs 0 immediately, without waiting for a `clk` edge.

Source files
------------

// File: rtl/bcd_cook_timer.sv
// MM:SS BCD cook timer. Debounced set/start buttons with optional auto-repeat,
// tick-driven countdown with pause/resume, and a timed alarm phase.
module bcd_cook_timer #(
    parameter int TICK_DIV      = 100_000_000,
    parameter int DB_CYCLES     = 1_000_000,
    parameter int REPEAT_CYCLES = 25_000_000,
    parameter int ALARM_SECS    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cook_time,
    input  logic       minutes_up,
    input  logic       seconds_up,
    input  logic       start,
    input  logic       clear,
    output logic [3:0] second_ones,
    output logic [3:0] second_tens,
    output logic [3:0] minute_ones,
    output logic [3:0] minute_tens,
    output logic       debounce_min,
    output logic       debounce_sec,
    output logic       enable_timer_cooktime,
    output logic       running,
    output logic       alarm
);

    localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int RW  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam int AW  = $clog2(ALARM_SECS + 1);
    localparam int NB  = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      raw_in;
    logic [3:0]      sync1_reg, sync2_reg;
    logic [NB-1:0]   db_lvl;
    logic [NB-1:0]   db_prev_reg;
    logic [NB-1:0]   db_rise;
    logic [1:0]      set_pulse;
    logic            cook_sync;
    logic            start_pulse;
    logic            in_set;
    logic            tick;
    logic            last_alarm_tick;
    logic            time_zero;
    logic            dec_hits_zero;
    logic [TW-1:0]   presc_reg;
    logic [AW-1:0]   alarm_cnt_reg;
    logic [3:0]      so_reg, st_reg, mo_reg, mt_reg;
    logic [3:0]      so_next, st_next, mo_next, mt_next;
    logic            en_reg, run_reg, alarm_reg;

    // Bit order: 0 minutes_up, 1 seconds_up, 2 start, 3 cook_time.
    assign raw_in = {cook_time, start, seconds_up, minutes_up};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign cook_sync = sync2_reg[3];

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_db
            logic [DBW-1:0] cnt_reg;
            logic           lvl_reg;

            // Any cycle where the input matches the current level restarts the count.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg <= '0;
                    lvl_reg <= 1'b0;
                end else if (sync2_reg[gi] == lvl_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DBW'(DB_CYCLES - 1)) begin
                    cnt_reg <= '0;
                    lvl_reg <= sync2_reg[gi];
                end else begin
                    cnt_reg <= cnt_reg + DBW'(1);
                end
            end

            assign db_lvl[gi] = lvl_reg;
        end
    endgenerate

    assign db_rise     = db_lvl & ~db_prev_reg;
    assign start_pulse = db_rise[2];
    assign in_set      = (state_reg == SET);

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rep
            if (REPEAT_CYCLES > 0) begin : g_on
                logic [RW-1:0] rep_cnt_reg;
                logic          fire;

                assign fire = db_lvl[gi] && in_set && (rep_cnt_reg == RW'(REPEAT_CYCLES - 1));

                // Interval is measured from the previous pulse, edge or repeat.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        rep_cnt_reg <= '0;
                    end else if (!db_lvl[gi] || !in_set || db_rise[gi] || fire) begin
                        rep_cnt_reg <= '0;
                    end else begin
                        rep_cnt_reg <= rep_cnt_reg + RW'(1);
                    end
                end

                assign set_pulse[gi] = db_rise[gi] | fire;
            end else begin : g_off
                assign set_pulse[gi] = db_rise[gi];
            end
        end
    endgenerate

    assign tick = ((state_reg == RUN) || (state_reg == DONE)) &&
                  (presc_reg == TW'(TICK_DIV - 1));
    assign last_alarm_tick = tick && (alarm_cnt_reg == AW'(ALARM_SECS - 1));
    assign time_zero = (mt_reg == 4'd0) && (mo_reg == 4'd0) &&
                       (st_reg == 4'd0) && (so_reg == 4'd0);
    assign dec_hits_zero = (mt_reg == 4'd0) && (mo_reg == 4'd0) &&
                           (st_reg == 4'd0) && (so_reg == 4'd1);

    always_comb begin
        state_next = state_reg;
        so_next    = so_reg;
        st_next    = st_reg;
        mo_next    = mo_reg;
        mt_next    = mt_reg;

        case (state_reg)
            IDLE: begin
                if (cook_sync) begin
                    state_next = SET;
                end else if (start_pulse && !time_zero) begin
                    state_next = RUN;
                end
            end
            SET: begin
                if (set_pulse[0]) begin
                    if (mo_reg == 4'd9) begin
                        mo_next = 4'd0;
                        mt_next = (mt_reg == 4'd9) ? 4'd0 : mt_reg + 4'd1;
                    end else begin
                        mo_next = mo_reg + 4'd1;
                    end
                end
                // Seconds wrap 59 -> 00 without carrying into minutes.
                if (set_pulse[1]) begin
                    if (so_reg == 4'd9) begin
                        so_next = 4'd0;
                        st_next = (st_reg == 4'd5) ? 4'd0 : st_reg + 4'd1;
                    end else begin
                        so_next = so_reg + 4'd1;
                    end
                end
                if (!cook_sync) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (tick) begin
                    if ((so_reg != 4'd0) || (st_reg != 4'd0)) begin
                        if (so_reg == 4'd0) begin
                            so_next = 4'd9;
                            st_next = st_reg - 4'd1;
                        end else begin
                            so_next = so_reg - 4'd1;
                        end
                    end else begin
                        so_next = 4'd9;
                        st_next = 4'd5;
                        if (mo_reg == 4'd0) begin
                            mo_next = 4'd9;
                            mt_next = mt_reg - 4'd1;
                        end else begin
                            mo_next = mo_reg - 4'd1;
                        end
                    end
                end
                if (tick && dec_hits_zero) begin
                    state_next = DONE;
                end else if (start_pulse) begin
                    state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (start_pulse) begin
                    state_next = RUN;
                end else if (cook_sync) begin
                    state_next = SET;
                end
            end
            DONE: begin
                if (cook_sync) begin
                    state_next = SET;
                end else if (start_pulse || last_alarm_tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (clear) begin
            state_next = IDLE;
            so_next    = 4'd0;
            st_next    = 4'd0;
            mo_next    = 4'd0;
            mt_next    = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            so_reg        <= 4'd0;
            st_reg        <= 4'd0;
            mo_reg        <= 4'd0;
            mt_reg        <= 4'd0;
            db_prev_reg   <= '0;
            presc_reg     <= '0;
            alarm_cnt_reg <= '0;
            en_reg        <= 1'b0;
            run_reg       <= 1'b0;
            alarm_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            so_reg      <= so_next;
            st_reg      <= st_next;
            mo_reg      <= mo_next;
            mt_reg      <= mt_next;
            db_prev_reg <= db_lvl;

            // Entering RUN or DONE always restarts a full tick period.
            if ((state_next != state_reg) && ((state_next == RUN) || (state_next == DONE))) begin
                presc_reg <= '0;
            end else if ((state_reg == RUN) || (state_reg == DONE)) begin
                presc_reg <= tick ? '0 : presc_reg + TW'(1);
            end else begin
                presc_reg <= '0;
            end

            if (state_reg != DONE) begin
                alarm_cnt_reg <= '0;
            end else if (tick) begin
                alarm_cnt_reg <= alarm_cnt_reg + AW'(1);
            end

            en_reg    <= (state_next == SET);
            run_reg   <= (state_next == RUN);
            alarm_reg <= (state_next == DONE);
        end
    end

    assign second_ones           = so_reg;
    assign second_tens           = st_reg;
    assign minute_ones           = mo_reg;
    assign minute_tens           = mt_reg;
    assign debounce_min          = db_lvl[0];
    assign debounce_sec          = db_lvl[1];
    assign enable_timer_cooktime = en_reg;
    assign running               = run_reg;
    assign alarm                 = alarm_reg;

endmodule

// File: tb/tb_bcd_cook_timer.sv
// Randomised scoreboard bench for bcd_cook_timer; the reference model keeps the
// time as total seconds and tracks button history with plain counters.
module tb_bcd_cook_timer;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int RP = 8;
    localparam int AS = 2;

    localparam int S_IDLE  = 0;
    localparam int S_SET   = 1;
    localparam int S_RUN   = 2;
    localparam int S_PAUSE = 3;
    localparam int S_DONE  = 4;

    logic clk        = 1'b0;
    logic reset      = 1'b1;
    logic cook_time  = 1'b0;
    logic minutes_up = 1'b0;
    logic seconds_up = 1'b0;
    logic start      = 1'b0;
    logic clear      = 1'b0;
    logic [3:0] second_ones, second_tens, minute_ones, minute_tens;
    logic debounce_min, debounce_sec, enable_timer_cooktime, running, alarm;

    bcd_cook_timer #(
        .TICK_DIV     (TD),
        .DB_CYCLES    (DB),
        .REPEAT_CYCLES(RP),
        .ALARM_SECS   (AS)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .cook_time            (cook_time),
        .minutes_up           (minutes_up),
        .seconds_up           (seconds_up),
        .start                (start),
        .clear                (clear),
        .second_ones          (second_ones),
        .second_tens          (second_tens),
        .minute_ones          (minute_ones),
        .minute_tens          (minute_tens),
        .debounce_min         (debounce_min),
        .debounce_sec         (debounce_sec),
        .enable_timer_cooktime(enable_timer_cooktime),
        .running              (running),
        .alarm                (alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [20:0] snap;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: time in total seconds, button history per input.
    int          m_state;
    int          m_secs;
    int          m_entered;
    bit          m_dly1[4];
    bit          m_dly2[4];
    bit          m_db[3];
    bit          m_rise[3];
    int          m_stable[3];
    int          m_anchor[2];
    logic [20:0] m_last;

    function automatic logic [20:0] dut_snap();
        return {minute_tens, minute_ones, second_tens, second_ones,
                debounce_min, debounce_sec, enable_timer_cooktime, running, alarm};
    endfunction

    function automatic logic [20:0] model_snap();
        int m = m_secs / 60;
        int s = m_secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                m_db[0], m_db[1], m_state == S_SET, m_state == S_RUN, m_state == S_DONE};
    endfunction

    task automatic model_reset();
        m_state   = S_IDLE;
        m_secs    = 0;
        m_entered = cyc;
        for (int b = 0; b < 4; b++) begin
            m_dly1[b] = 1'b0;
            m_dly2[b] = 1'b0;
        end
        for (int b = 0; b < 3; b++) begin
            m_db[b]     = 1'b0;
            m_rise[b]   = 1'b0;
            m_stable[b] = 0;
        end
        for (int b = 0; b < 2; b++) m_anchor[b] = cyc;
    endtask

    task automatic model_step();
        bit   raw[4];
        bit   seen[4];
        bit   pulse[3];
        bit   tick;
        bit   last_tick;
        int   nxt;
        int   m;
        int   s;
        exp_t e;
        if (!reset) begin
            model_reset();
        end else begin
            raw = '{minutes_up, seconds_up, start, cook_time};
            // Each input reaches the debouncer two edges after it is sampled.
            for (int b = 0; b < 4; b++) begin
                seen[b]   = m_dly2[b];
                m_dly2[b] = m_dly1[b];
                m_dly1[b] = raw[b];
            end
            for (int b = 0; b < 3; b++) pulse[b] = m_rise[b];
            for (int b = 0; b < 2; b++) begin
                if (RP > 0 && m_db[b] && m_state == S_SET && (cyc - m_anchor[b]) == RP)
                    pulse[b] = 1'b1;
                if (!m_db[b] || m_state != S_SET || pulse[b])
                    m_anchor[b] = cyc;
            end
            for (int b = 0; b < 3; b++) begin
                m_rise[b] = 1'b0;
                if (seen[b] != m_db[b]) begin
                    m_stable[b]++;
                    if (m_stable[b] == DB) begin
                        m_db[b]     = seen[b];
                        m_stable[b] = 0;
                        m_rise[b]   = seen[b];
                    end
                end else begin
                    m_stable[b] = 0;
                end
            end

            tick      = (m_state == S_RUN || m_state == S_DONE) && ((cyc - m_entered) % TD == 0);
            last_tick = tick && (m_state == S_DONE) && ((cyc - m_entered) / TD == AS);
            nxt       = m_state;
            m         = m_secs / 60;
            s         = m_secs % 60;
            case (m_state)
                S_IDLE: begin
                    if (seen[3]) nxt = S_SET;
                    else if (pulse[2] && m_secs != 0) nxt = S_RUN;
                end
                S_SET: begin
                    if (pulse[0]) m = (m + 1) % 100;
                    if (pulse[1]) s = (s + 1) % 60;
                    m_secs = m * 60 + s;
                    if (!seen[3]) nxt = S_IDLE;
                end
                S_RUN: begin
                    if (tick) m_secs = m_secs - 1;
                    if (tick && m_secs == 0) nxt = S_DONE;
                    else if (pulse[2]) nxt = S_PAUSE;
                end
                S_PAUSE: begin
                    if (pulse[2]) nxt = S_RUN;
                    else if (seen[3]) nxt = S_SET;
                end
                S_DONE: begin
                    if (seen[3]) nxt = S_SET;
                    else if (pulse[2] || last_tick) nxt = S_IDLE;
                end
                default: nxt = S_IDLE;
            endcase
            if (clear) begin
                nxt    = S_IDLE;
                m_secs = 0;
            end
            if (nxt != m_state && (nxt == S_RUN || nxt == S_DONE)) m_entered = cyc;
            m_state = nxt;
        end
        if (model_snap() != m_last) begin
            e.cyc  = cyc;
            e.snap = model_snap();
            exp_q.push_back(e);
            m_last = e.snap;
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       minutes_up = v;
            1:       seconds_up = v;
            default: start      = v;
        endcase
    endtask

    task automatic press(input int which, input int hold, input int gap);
        set_btn(which, 1'b1);
        step(hold);
        set_btn(which, 1'b0);
        step(gap);
    endtask

    // Monitor: every change of the DUT's outputs consumes one expectation.
    initial begin
        logic [20:0] last_seen;
        logic [20:0] now_seen;
        exp_t        e;
        last_seen = '0;
        forever begin
            @(posedge clk);
            #1;
            now_seen = dut_snap();
            if (now_seen !== last_seen) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change cycle %0d: got %h, required %h (no change)",
                             cyc, now_seen, last_seen);
                end else begin
                    e = exp_q.pop_front();
                    if (e.snap !== now_seen || e.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL scoreboard cycle %0d: got %h, required %h at cycle %0d",
                                 cyc, now_seen, e.snap, e.cyc);
                    end
                end
                last_seen = now_seen;
            end
        end
    end

    initial begin
        model_reset();
        m_last = '0;
        #2 reset = 1'b0;
        step(3);
        n_checks++;
        if (dut_snap() !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h, required %h", dut_snap(), 21'd0);
        end
        reset = 1'b1;
        step(2);

        // Set a time, run, pause, resume, clear.
        cook_time = 1'b1;
        step(3);
        repeat (1 + $urandom_range(0, 2)) press(0, 4 + $urandom_range(0, 2), 6);
        repeat (2 + $urandom_range(0, 2)) press(1, 4 + $urandom_range(0, 2), 6);
        cook_time = 1'b0;
        step(3);
        press(2, 5, 0);
        step(10 + $urandom_range(0, 8));
        press(2, 5, 3);
        step($urandom_range(5, 15));
        press(2, 5, 0);
        step($urandom_range(6, 14));
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(3);

        // Load 01:00 and run through borrow, alarm and automatic return to IDLE.
        cook_time = 1'b1;
        step(3);
        press(0, 5, 6);
        cook_time = 1'b0;
        step(3);
        press(2, 5, 0);
        step(4 * 61 + 30);

        // Bouncing seconds_up must not increment; a clean hold then increments once.
        cook_time = 1'b1;
        step(3 + $urandom_range(0, 1));
        for (int i = 0; i < 10; i++) begin
            seconds_up = ~seconds_up;
            step(2);
        end
        seconds_up = 1'b1;
        step(7);
        seconds_up = 1'b0;
        step(8);

        // Auto-repeat on a long hold, including the 59 -> 00 wrap.
        seconds_up = 1'b1;
        step(5 + 8 * $urandom_range(50, 56));
        seconds_up = 1'b0;
        step(12);
        seconds_up = 1'b1;
        step(30);
        seconds_up = 1'b0;
        step(12);
        cook_time = 1'b0;
        step(3);

        // Asynchronous reset while running.
        cook_time = 1'b1;
        step(3);
        press(0, 5, 6);
        cook_time = 1'b0;
        step(3);
        press(2, 5, 0);
        step(6);
        reset = 1'b0;
        #1;
        n_checks++;
        if (dut_snap() !== 21'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h, required %h", dut_snap(), 21'd0);
        end
        step(2);
        reset = 1'b1;
        step(3);

        // Random input soak.
        for (int i = 0; i < 80; i++) begin
            cook_time  = ($urandom_range(0, 2) == 0);
            minutes_up = $urandom_range(0, 1);
            seconds_up = $urandom_range(0, 1);
            start      = $urandom_range(0, 1);
            clear      = ($urandom_range(0, 15) == 0);
            step(1 + $urandom_range(0, 11));
        end
        cook_time  = 1'b0;
        minutes_up = 1'b0;
        seconds_up = 1'b0;
        start      = 1'b0;
        clear      = 1'b0;
        step(60);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expectations: got %0d outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
